// File: rtl/hazard_scoreboard_if.sv
// Interface between the D-stage issue logic and the hazard scoreboard.
// The master drives the D-stage request; the slave returns stall and per-stage write state.
interface hazard_scoreboard_if #(
   parameter int TNEW_W      = 2,
   parameter int STALL_CNT_W = 32
);
   logic [4:0]             D_A;
   logic [TNEW_W-1:0]      D_Tnew;
   logic [4:0]             D_rs_ad;
   logic [4:0]             D_rt_ad;
   logic [TNEW_W-1:0]      D_rs_Tuse;
   logic [TNEW_W-1:0]      D_rt_Tuse;
   logic                   D_rs_used;
   logic                   D_rt_used;
   logic                   ext_stall;
   logic                   E_flush;
   logic                   stall;
   logic [4:0]             E_A;
   logic [4:0]             M_A;
   logic [4:0]             W_A;
   logic [TNEW_W-1:0]      E_Tnew;
   logic [TNEW_W-1:0]      M_Tnew;
   logic                   E_ready;
   logic                   M_ready;
   logic                   W_ready;
   logic [STALL_CNT_W-1:0] stall_cnt;

   modport master (
      output D_A, D_Tnew, D_rs_ad, D_rt_ad, D_rs_Tuse, D_rt_Tuse,
             D_rs_used, D_rt_used, ext_stall, E_flush,
      input  stall, E_A, M_A, W_A, E_Tnew, M_Tnew,
             E_ready, M_ready, W_ready, stall_cnt
   );

   modport slave (
      input  D_A, D_Tnew, D_rs_ad, D_rt_ad, D_rs_Tuse, D_rt_Tuse,
             D_rs_used, D_rt_used, ext_stall, E_flush,
      output stall, E_A, M_A, W_A, E_Tnew, M_Tnew,
             E_ready, M_ready, W_ready, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination/Tnew of the E, M, W stage writes and raises the D-stage Tuse/Tnew stall.
// Optional stall statistics counter enabled by defining SB_STALL_STAT_EN.
module hazard_scoreboard #(
   parameter int TNEW_W      = 2,
   parameter int STALL_CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   hazard_scoreboard_if.slave sb
);
   logic [4:0]        r_e_a, r_m_a, r_w_a;
   logic [TNEW_W-1:0] r_e_tnew, r_m_tnew, r_w_tnew;
   logic              w_hazard_rs, w_hazard_rt, w_stall, w_bubble;
   logic [TNEW_W-1:0] w_d_tnew;

   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
      return (x == '0) ? '0 : x - TNEW_W'(1);
   endfunction

   // A younger E entry never masks an older M entry for the same register.
   assign w_hazard_rs = sb.D_rs_used && (sb.D_rs_ad != 5'd0) &&
                        (((sb.D_rs_ad == r_e_a) && (r_e_tnew > sb.D_rs_Tuse)) ||
                         ((sb.D_rs_ad == r_m_a) && (r_m_tnew > sb.D_rs_Tuse)));
   assign w_hazard_rt = sb.D_rt_used && (sb.D_rt_ad != 5'd0) &&
                        (((sb.D_rt_ad == r_e_a) && (r_e_tnew > sb.D_rt_Tuse)) ||
                         ((sb.D_rt_ad == r_m_a) && (r_m_tnew > sb.D_rt_Tuse)));

   assign w_stall  = w_hazard_rs | w_hazard_rt | sb.ext_stall;
   assign w_bubble = w_stall | sb.E_flush;
   assign w_d_tnew = (sb.D_A == 5'd0) ? '0 : sb.D_Tnew;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_e_a    <= '0;
         r_m_a    <= '0;
         r_w_a    <= '0;
         r_e_tnew <= '0;
         r_m_tnew <= '0;
         r_w_tnew <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage shift from the old values in one edge.
         r_w_a    <= r_m_a;
         r_w_tnew <= sat_dec(r_m_tnew);
         r_m_a    <= r_e_a;
         r_m_tnew <= sat_dec(r_e_tnew);
         if (w_bubble) begin
            r_e_a    <= '0;
            r_e_tnew <= '0;
         end else begin
            r_e_a    <= sb.D_A;
            r_e_tnew <= w_d_tnew;
         end
      end
   end

   assign sb.stall   = w_stall;
   assign sb.E_A     = r_e_a;
   assign sb.M_A     = r_m_a;
   assign sb.W_A     = r_w_a;
   assign sb.E_Tnew  = r_e_tnew;
   assign sb.M_Tnew  = r_m_tnew;
   assign sb.E_ready = (r_e_a != 5'd0) && (r_e_tnew == '0);
   assign sb.M_ready = (r_m_a != 5'd0) && (r_m_tnew == '0);
   assign sb.W_ready = (r_w_a != 5'd0) && (r_w_tnew == '0);

`ifdef SB_STALL_STAT_EN
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
   end

   assign sb.stall_cnt = r_stall_cnt;
`else
   assign sb.stall_cnt = {STALL_CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard; stall_cnt expectations follow SB_STALL_STAT_EN.
module tb_hazard_scoreboard;
   localparam int TW = 2;
   localparam int CW = 32;
`ifdef SB_STALL_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_cnt = 0;

   hazard_scoreboard_if #(.TNEW_W(TW), .STALL_CNT_W(CW)) sb_if ();

   hazard_scoreboard #(.TNEW_W(TW), .STALL_CNT_W(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sb      (sb_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      sb_if.D_A       = '0;
      sb_if.D_Tnew    = '0;
      sb_if.D_rs_ad   = '0;
      sb_if.D_rt_ad   = '0;
      sb_if.D_rs_Tuse = '0;
      sb_if.D_rt_Tuse = '0;
      sb_if.D_rs_used = 1'b0;
      sb_if.D_rt_used = 1'b0;
      sb_if.ext_stall = 1'b0;
      sb_if.E_flush   = 1'b0;
   endtask

   task automatic issue(input logic [4:0] a, input logic [TW-1:0] tnew);
      sb_if.D_A    = a;
      sb_if.D_Tnew = tnew;
   endtask

   task automatic read_rs(input logic [4:0] ad, input logic [TW-1:0] tuse);
      sb_if.D_rs_ad   = ad;
      sb_if.D_rs_Tuse = tuse;
      sb_if.D_rs_used = 1'b1;
   endtask

   function automatic logic [31:0] cnt_exp();
      return STAT ? 32'(exp_cnt) : 32'd0;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_E_A", sb_if.E_A, 0);
      check("rst_M_A", sb_if.M_A, 0);
      check("rst_W_A", sb_if.W_A, 0);
      check("rst_E_Tnew", sb_if.E_Tnew, 0);
      check("rst_M_Tnew", sb_if.M_Tnew, 0);
      check("rst_ready", {sb_if.E_ready, sb_if.M_ready, sb_if.W_ready}, 0);
      check("rst_stall", sb_if.stall, 0);
      check("rst_cnt", sb_if.stall_cnt, 0);
      reset_n = 1'b1;

      // Load-use: lw $8 then a consumer of $8 at Tuse=0
      issue(5'd8, 2'd2);
      settle();
      check("lu_issue_stall", sb_if.stall, 0);
      tick();
      issue(5'd10, 2'd1);
      read_rs(5'd8, 2'd0);
      settle();
      check("lu_stall1", sb_if.stall, 1);
      check("lu_E_A", sb_if.E_A, 8);
      check("lu_E_Tnew", sb_if.E_Tnew, 2);
      exp_cnt++;
      tick();
      check("lu_stall2", sb_if.stall, 1);
      check("lu_bubble1", sb_if.E_A, 0);
      check("lu_M_A", sb_if.M_A, 8);
      check("lu_M_Tnew", sb_if.M_Tnew, 1);
      check("lu_M_ready", sb_if.M_ready, 0);
      exp_cnt++;
      tick();
      check("lu_release", sb_if.stall, 0);
      check("lu_bubble2", sb_if.E_A, 0);
      check("lu_W_A", sb_if.W_A, 8);
      check("lu_W_ready", sb_if.W_ready, 1);
      check("lu_cnt", sb_if.stall_cnt, cnt_exp());
      tick();
      check("lu_consumer_E_A", sb_if.E_A, 10);
      check("lu_consumer_E_Tnew", sb_if.E_Tnew, 1);
      idle();
      repeat (3) tick();

      // ALU-to-ALU with Tuse=1: no stall
      issue(5'd9, 2'd1);
      tick();
      idle();
      sb_if.D_rt_ad   = 5'd9;
      sb_if.D_rt_Tuse = 2'd1;
      sb_if.D_rt_used = 1'b1;
      settle();
      check("alu_stall", sb_if.stall, 0);
      check("alu_E_Tnew", sb_if.E_Tnew, 1);
      check("alu_E_ready", sb_if.E_ready, 0);
      tick();
      check("alu_M_A", sb_if.M_A, 9);
      check("alu_M_Tnew", sb_if.M_Tnew, 0);
      check("alu_M_ready", sb_if.M_ready, 1);
      idle();
      read_rs(5'd9, 2'd0);
      settle();
      check("alu_fwd_from_M", sb_if.stall, 0);
      idle();
      repeat (3) tick();

      // $0 destination and unused sources
      issue(5'd0, 2'd2);
      tick();
      idle();
      read_rs(5'd0, 2'd0);
      settle();
      check("zero_stall", sb_if.stall, 0);
      check("zero_E_A", sb_if.E_A, 0);
      check("zero_E_Tnew", sb_if.E_Tnew, 0);
      check("zero_E_ready", sb_if.E_ready, 0);
      idle();
      issue(5'd5, 2'd2);
      tick();
      idle();
      sb_if.D_rs_ad = 5'd5;
      sb_if.D_rt_ad = 5'd5;
      settle();
      check("unused_stall", sb_if.stall, 0);
      sb_if.D_rt_used = 1'b1;
      settle();
      check("rt_hazard", sb_if.stall, 1);
      idle();
      settle();
      repeat (3) tick();

      // Same register in E (ready) and M (pending): M must still stall
      issue(5'd7, 2'd3);
      tick();
      issue(5'd7, 2'd0);
      tick();
      idle();
      read_rs(5'd7, 2'd1);
      settle();
      check("dup_E_ready", sb_if.E_ready, 1);
      check("dup_M_Tnew", sb_if.M_Tnew, 2);
      check("dup_stall", sb_if.stall, 1);
      idle();
      settle();
      repeat (3) tick();

      // ext_stall for 3 cycles, no data hazard
      issue(5'd4, 2'd1);
      sb_if.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("ext_stall_%0d", i), sb_if.stall, 1);
         exp_cnt++;
         tick();
         check($sformatf("ext_bubble_%0d", i), sb_if.E_A, 0);
      end
      sb_if.ext_stall = 1'b0;
      settle();
      check("ext_release", sb_if.stall, 0);
      check("ext_cnt", sb_if.stall_cnt, cnt_exp());
      idle();

      // ext_stall overlapping a load-use hazard still counts one per cycle
      issue(5'd12, 2'd2);
      tick();
      idle();
      read_rs(5'd12, 2'd0);
      sb_if.ext_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("ovl_stall_%0d", i), sb_if.stall, 1);
         exp_cnt++;
         tick();
      end
      sb_if.ext_stall = 1'b0;
      settle();
      check("ovl_W_not_checked", sb_if.stall, 0);
      check("ovl_cnt", sb_if.stall_cnt, cnt_exp());
      idle();
      repeat (3) tick();

      // Stall and flush on the same edge: one bubble only
      issue(5'd6, 2'd1);
      tick();
      issue(5'd11, 2'd1);
      sb_if.ext_stall = 1'b1;
      sb_if.E_flush   = 1'b1;
      settle();
      exp_cnt++;
      tick();
      check("sf_E_A", sb_if.E_A, 0);
      check("sf_M_A", sb_if.M_A, 6);
      check("sf_M_Tnew", sb_if.M_Tnew, 0);
      sb_if.ext_stall = 1'b0;
      sb_if.E_flush   = 1'b0;
      settle();
      check("sf_release", sb_if.stall, 0);
      tick();
      check("sf_next_E_A", sb_if.E_A, 11);
      issue(5'd13, 2'd1);
      sb_if.E_flush = 1'b1;
      settle();
      check("flush_only_stall", sb_if.stall, 0);
      tick();
      check("flush_E_A", sb_if.E_A, 0);
      check("flush_M_A", sb_if.M_A, 11);
      check("sf_cnt", sb_if.stall_cnt, cnt_exp());
      idle();
      repeat (3) tick();

      // Asynchronous reset between edges while stalled
      issue(5'd3, 2'd1);
      tick();
      issue(5'd8, 2'd2);
      tick();
      idle();
      read_rs(5'd8, 2'd0);
      settle();
      check("pre_rst_stall", sb_if.stall, 1);
      check("pre_rst_M_ready", sb_if.M_ready, 1);
      check("pre_rst_E_A", sb_if.E_A, 8);
      #2;
      reset_n = 1'b0;
      exp_cnt = 0;
      #1;
      check("async_E_A", sb_if.E_A, 0);
      check("async_M_A", sb_if.M_A, 0);
      check("async_W_A", sb_if.W_A, 0);
      check("async_ready", {sb_if.E_ready, sb_if.M_ready, sb_if.W_ready}, 0);
      check("async_stall", sb_if.stall, 0);
      check("async_cnt", sb_if.stall_cnt, cnt_exp());
      idle();
      tick();
      reset_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
